// File: rtl/iter_divider.sv
// iter_divider: multi-cycle 32-bit restoring divider for DLX div/divu.
// Ports: clk, reset (async, active-high), start, divu, dividend, divisor
//   -> quotient, remainder, busy, done, div_zero. Buses are [0:31], bit 0 = MSB.
// Build option: define DIV_EARLY_EXIT_EN to finish in one edge when
//   |divisor| > |dividend| (quotient is then 0, remainder the raw dividend).
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             divu,
  input  logic [0:WIDTH-1] dividend,
  input  logic [0:WIDTH-1] divisor,
  output logic [0:WIDTH-1] quotient,
  output logic [0:WIDTH-1] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic zero_q, zero_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic dz_q, dz_d;
`ifdef DIV_EARLY_EXIT_EN
  logic early_q, early_d;
`endif

  logic [WIDTH-1:0] a_raw, b_raw, a_mag, b_mag;
  logic [WIDTH:0]   trial, diff;
  logic             qbit, accept;
  logic [WIDTH-1:0] quo_nx, rem_nx;

  assign a_raw = dividend;
  assign b_raw = divisor;
  assign a_mag = (!divu && a_raw[WIDTH-1]) ? -a_raw : a_raw;
  assign b_mag = (!divu && b_raw[WIDTH-1]) ? -b_raw : b_raw;
  assign accept = start & ~busy_q;

  // The dividend register shifts out its MSB into the partial remainder
  // while the new quotient bit shifts in at the bottom.
  assign trial  = {rem_q, dvd_q[WIDTH-1]};
  assign diff   = trial - {1'b0, dvs_q};
  assign qbit   = ~diff[WIDTH];
  assign rem_nx = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign quo_nx = {dvd_q[WIDTH-2:0], qbit};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    raw_d   = raw_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    busy_d  = busy_q;
    done_d  = done_q;
    dz_d    = dz_q;
`ifdef DIV_EARLY_EXIT_EN
    early_d = early_q;
`endif
    unique case (state_q)
      S_CALC: begin
        dvd_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dz_d    = zero_q;
          quo_d   = zero_q ? '1 : (qneg_q ? -quo_nx : quo_nx);
          rmd_d   = zero_q ? raw_q : (rneg_q ? -rem_nx : rem_nx);
        end
`ifdef DIV_EARLY_EXIT_EN
        if (early_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dz_d    = 1'b0;
          quo_d   = '0;
          rmd_d   = raw_q;
        end
`endif
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        if (accept) begin
          state_d = S_CALC;
          busy_d  = 1'b1;
          cnt_d   = '0;
          dvd_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          raw_d   = a_raw;
          qneg_d  = ~divu & (a_raw[WIDTH-1] ^ b_raw[WIDTH-1]);
          rneg_d  = ~divu & a_raw[WIDTH-1];
          zero_d  = (b_raw == '0);
`ifdef DIV_EARLY_EXIT_EN
          early_d = (b_raw != '0) && (b_mag > a_mag);
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      raw_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
`ifdef DIV_EARLY_EXIT_EN
      early_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      raw_q   <= raw_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
`ifdef DIV_EARLY_EXIT_EN
      early_q <= early_d;
`endif
    end
  end

  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed bench for iter_divider with a behavioural
// arithmetic model checked on every done pulse plus literal expectations.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        divu;
  logic [0:31] dividend;
  logic [0:31] divisor;
  logic [0:31] quotient;
  logic [0:31] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t expq[$];

  iter_divider dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .divu(divu),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input bit du, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    longint sa, sb;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dz = 1'b1;
    end else if (du) begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
      e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic int lat(input bit du, input logic [31:0] a,
                             input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (!du && a[31]) ? -a : a;
    mb = (!du && b[31]) ? -b : b;
`ifdef DIV_EARLY_EXIT_EN
    if (b != 0 && mb > ma) return 1;
`endif
    if (ma == mb + 1) return 32;
    return 32;
  endfunction

  // Compare process: every done pulse is checked against the model.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (expq.size() == 0) begin
        tests++; fails++;
        $display("FAIL spurious_done: got done=1 expected no pending op");
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("model_q", quotient, e.q);
        chk("model_r", remainder, e.r);
        chk("model_dz", {31'b0, div_zero}, {31'b0, e.dz});
      end
    end
  end

  task automatic issue(input bit du, input logic [31:0] a,
                       input logic [31:0] b);
    divu = du; dividend = a; divisor = b; start = 1'b1;
    expq.push_back(model(du, a, b));
  endtask

  // Starts at or before the accept edge; returns #1 after the done edge.
  task automatic wait_done(input string nm, input int exp_lat,
                           input logic [31:0] lq, input logic [31:0] lr,
                           input bit ldz, input int glitch);
    int n;
    bit got;
    bit busy_ok;
    @(posedge clk); #1;
    start = 1'b0;
    chk({nm, "_busy_e0"}, {31'b0, busy}, 32'd1);
    n = 0; got = 0; busy_ok = 1;
    while (!got && n < 40) begin
      if (glitch > 0 && n == glitch - 1) begin
        start = 1'b1; dividend = 32'd7; divisor = 32'd7;
      end
      @(posedge clk); n++; #1;
      if (glitch > 0 && n == glitch) start = 1'b0;
      if (done) got = 1;
      else if (!busy) busy_ok = 0;
    end
    chk({nm, "_lat"}, n, exp_lat);
    chk({nm, "_busy_hold"}, {31'b0, busy_ok}, 32'd1);
    chk({nm, "_q"}, quotient, lq);
    chk({nm, "_r"}, remainder, lr);
    chk({nm, "_dz"}, {31'b0, div_zero}, {31'b0, ldz});
    chk({nm, "_busy_done"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic zero_outs(input string nm);
    chk({nm, "_q0"}, quotient, 32'd0);
    chk({nm, "_r0"}, remainder, 32'd0);
    chk({nm, "_ctl0"}, {29'b0, busy, done, div_zero}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    bit seen;
    reset = 1'b1; start = 1'b0; divu = 1'b0;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    #1 zero_outs("reset");
    @(negedge clk) reset = 1'b0;

    // 1: unsigned 100/7
    @(negedge clk) issue(1'b1, 32'd100, 32'd7);
    wait_done("t1", 32, 32'd14, 32'd2, 1'b0, 0);

    // 2: signed -100/7
    @(negedge clk) issue(1'b0, 32'hFFFFFF9C, 32'd7);
    wait_done("t2", lat(0, 32'hFFFFFF9C, 7), 32'hFFFFFFF2,
              32'hFFFFFFFE, 1'b0, 0);

    // 3: divide by zero
    @(negedge clk) issue(1'b1, 32'h12345678, 32'd0);
    wait_done("t3", 32, 32'hFFFFFFFF, 32'h12345678, 1'b1, 0);

    // 4: overflow, then back-to-back start in the done cycle
    @(negedge clk) issue(1'b0, 32'h80000000, 32'hFFFFFFFF);
    wait_done("t4a", 32, 32'h80000000, 32'd0, 1'b0, 0);
    issue(1'b0, 32'd9, 32'd3);
    wait_done("t4b", 32, 32'd3, 32'd0, 1'b0, 0);

    // 5: reset mid-operation, then ignored start while busy
    @(negedge clk) issue(1'b0, 32'd1000, 32'd10);
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #1 zero_outs("t5_rst");
    expq.delete();
    @(negedge clk) reset = 1'b0;
    seen = 0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("t5_no_done", {31'b0, seen}, 32'd0);
    @(negedge clk) issue(1'b0, 32'd50, 32'd5);
    wait_done("t5b", 32, 32'd10, 32'd0, 1'b0, 5);

    // 6: divisor larger than dividend
    @(negedge clk) issue(1'b1, 32'd5, 32'd9);
`ifdef DIV_EARLY_EXIT_EN
    wait_done("t6", 1, 32'd0, 32'd5, 1'b0, 0);
`else
    wait_done("t6", 32, 32'd0, 32'd5, 1'b0, 0);
`endif

    // extra sign and boundary cases
    @(negedge clk) issue(1'b1, 32'hFFFFFFFF, 32'd1);
    wait_done("x1", 32, 32'hFFFFFFFF, 32'd0, 1'b0, 0);
    @(negedge clk) issue(1'b0, 32'd7, 32'hFFFFFFFE);
    wait_done("x2", 32, 32'hFFFFFFFD, 32'd1, 1'b0, 0);
    @(negedge clk) issue(1'b0, 32'hFFFFFFF9, 32'hFFFFFFFE);
    wait_done("x3", 32, 32'd3, 32'hFFFFFFFF, 1'b0, 0);
    @(negedge clk) issue(1'b0, 32'hFFFFFFFB, 32'd0);
    wait_done("x4", 32, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, 0);
    @(negedge clk) issue(1'b0, 32'hFFFFFFFE, 32'd3);
    wait_done("x5", lat(0, 32'hFFFFFFFE, 3), 32'd0,
              32'hFFFFFFFE, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", expq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
